// File: rtl/multi_channel_saturating_adder.sv
// CHANNELS-lane signed adder with per-beat saturate/wrap mode, even and clamp flags,
// a 2-stage valid/ready pipeline and a sticky saturation-event counter.

module msa_lane #(
    parameter int WIDTH   = 32,
    parameter int SAT_MAX = 100,
    parameter int SAT_MIN = -100
) (
    input  logic signed [WIDTH:0]   sum,
    input  logic                    wrap,
    output logic        [WIDTH-1:0] res,
    output logic                    is_even,
    output logic                    sat
);
    localparam logic signed [WIDTH:0] MAX_X = (WIDTH+1)'(SAT_MAX);
    localparam logic signed [WIDTH:0] MIN_X = (WIDTH+1)'(SAT_MIN);

    always_comb begin
        res = sum[WIDTH-1:0];
        sat = 1'b0;
        if (!wrap) begin
            if (sum > MAX_X) begin
                res = MAX_X[WIDTH-1:0];
                sat = 1'b1;
            end else if (sum < MIN_X) begin
                res = MIN_X[WIDTH-1:0];
                sat = 1'b1;
            end
        end
        // parity taken after clamping so it describes the value actually emitted
        is_even = ~res[0];
    end
endmodule

module multi_channel_saturating_adder #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 4,
    parameter int SAT_MAX  = 100,
    parameter int SAT_MIN  = -100,
    parameter int CNT_W    = 16
) (
    input  logic                         in_clk,
    input  logic                         in_rst_n,
    input  logic                         in_valid,
    output logic                         out_ready,
    input  logic [CHANNELS*WIDTH-1:0]    in_a,
    input  logic [CHANNELS*WIDTH-1:0]    in_b,
    input  logic                         in_mode,
    input  logic                         in_ready,
    input  logic                         in_clr_count,
    output logic                         out_valid,
    output logic [CHANNELS*WIDTH-1:0]    out_sum,
    output logic [CHANNELS-1:0]          out_is_even,
    output logic [CHANNELS-1:0]          out_sat_flags,
    output logic [CNT_W-1:0]             out_sat_count
);
    localparam int PW = $clog2(CHANNELS + 1);

    logic                           s1_valid_q, s1_valid_d;
    logic                           s1_mode_q, s1_mode_d;
    logic [CHANNELS-1:0][WIDTH:0]   s1_sum_q, s1_sum_d;
    logic                           out_valid_q, out_valid_d;
    logic [CHANNELS-1:0][WIDTH-1:0] sum_q, sum_d;
    logic [CHANNELS-1:0]            even_q, even_d;
    logic [CHANNELS-1:0]            sat_q, sat_d;
    logic [CNT_W-1:0]               count_q, count_d;

    logic [CHANNELS-1:0][WIDTH:0]   lane_sum;
    logic [CHANNELS-1:0][WIDTH-1:0] lane_res;
    logic [CHANNELS-1:0]            lane_even, lane_sat;
    logic                           s1_adv, s2_adv, in_xfer, out_xfer;
    logic [PW-1:0]                  pop;
    logic [CNT_W:0]                 cnt_sum;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
        // sign-extend by one bit so the add cannot overflow
        assign lane_sum[k] = {in_a[k*WIDTH+WIDTH-1], in_a[k*WIDTH +: WIDTH]}
                           + {in_b[k*WIDTH+WIDTH-1], in_b[k*WIDTH +: WIDTH]};

        msa_lane #(
            .WIDTH   (WIDTH),
            .SAT_MAX (SAT_MAX),
            .SAT_MIN (SAT_MIN)
        ) u_lane (
            .sum     (s1_sum_q[k]),
            .wrap    (s1_mode_q),
            .res     (lane_res[k]),
            .is_even (lane_even[k]),
            .sat     (lane_sat[k])
        );
    end

    always_comb begin
        s2_adv   = !out_valid_q || in_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_xfer  = in_valid && s1_adv;
        out_xfer = out_valid_q && in_ready;

        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_sum_d   = s1_sum_q;
        if (in_xfer) begin
            s1_mode_d = in_mode;
            s1_sum_d  = lane_sum;
        end

        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
        sum_d       = sum_q;
        even_d      = even_q;
        sat_d       = sat_q;
        if (s2_adv && s1_valid_q) begin
            sum_d  = lane_res;
            even_d = lane_even;
            sat_d  = lane_sat;
        end

        pop = '0;
        for (int k = 0; k < CHANNELS; k++) pop = pop + PW'(sat_q[k]);

        // a clear folded into a transfer restarts the total from this beat
        cnt_sum = (in_clr_count ? '0 : {1'b0, count_q}) + (CNT_W+1)'(pop);
        count_d = count_q;
        if (out_xfer)          count_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        else if (in_clr_count) count_d = '0;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= 1'b0;
            s1_sum_q    <= '0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            even_q      <= '0;
            sat_q       <= '0;
            count_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s1_sum_q    <= s1_sum_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            even_q      <= even_d;
            sat_q       <= sat_d;
            count_q     <= count_d;
        end
    end

    assign out_ready     = s1_adv;
    assign out_valid     = out_valid_q;
    assign out_sum       = sum_q;
    assign out_is_even   = even_q;
    assign out_sat_flags = sat_q;
    assign out_sat_count = count_q;
endmodule

// File: tb/tb_multi_channel_saturating_adder.sv
// Bench for multi_channel_saturating_adder: directed steps plus random traffic,
// scored against a plain-arithmetic reference queue and counter model.

module tb_multi_channel_saturating_adder;
    localparam int W     = 32;
    localparam int C     = 4;
    localparam int CNT_W = 16;
    localparam int BW    = W * C;
    localparam longint SMAX = 100;
    localparam longint SMIN = -100;
    localparam int unsigned CMAX = (1 << CNT_W) - 1;

    logic           in_clk = 1'b0;
    logic           in_rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_mode = 1'b0;
    logic           in_ready = 1'b1;
    logic           in_clr_count = 1'b0;
    logic [BW-1:0]  in_a = '0;
    logic [BW-1:0]  in_b = '0;
    wire            out_ready;
    wire            out_valid;
    wire [BW-1:0]   out_sum;
    wire [C-1:0]    out_is_even;
    wire [C-1:0]    out_sat_flags;
    wire [CNT_W-1:0] out_sat_count;

    multi_channel_saturating_adder #(
        .WIDTH(W), .CHANNELS(C), .SAT_MAX(100), .SAT_MIN(-100), .CNT_W(CNT_W)
    ) dut (
        .in_clk        (in_clk),
        .in_rst_n      (in_rst_n),
        .in_valid      (in_valid),
        .out_ready     (out_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_mode       (in_mode),
        .in_ready      (in_ready),
        .in_clr_count  (in_clr_count),
        .out_valid     (out_valid),
        .out_sum       (out_sum),
        .out_is_even   (out_is_even),
        .out_sat_flags (out_sat_flags),
        .out_sat_count (out_sat_count)
    );

    always #5 in_clk = ~in_clk;

    typedef struct packed {
        logic [BW-1:0] sum;
        logic [C-1:0]  even;
        logic [C-1:0]  sat;
    } beat_t;

    beat_t       exp_q[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cnt_m = 0;

    function automatic beat_t model(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic mode);
        beat_t  r;
        longint s;
        r = '0;
        for (int k = 0; k < C; k++) begin
            s = longint'($signed(a[k*W +: W])) + longint'($signed(b[k*W +: W]));
            if (!mode && s > SMAX) begin
                s = SMAX; r.sat[k] = 1'b1;
            end else if (!mode && s < SMIN) begin
                s = SMIN; r.sat[k] = 1'b1;
            end
            r.sum[k*W +: W] = W'(s);
            r.even[k]       = (s % 2 == 0);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [W-1:0] lane_val(input int kind);
        case (kind)
            1:       return W'($urandom_range(200, 1000000));
            2:       return W'(-int'($urandom_range(200, 1000000)));
            3:       return W'(int'($urandom_range(0, 80)) - 40);
            default: return W'($urandom);
        endcase
    endfunction

    // nsat < 0: full-range random lanes; else first nsat lanes overflow, the rest stay in range
    task automatic set_beat(input int nsat, input logic mode);
        int kind;
        for (int k = 0; k < C; k++) begin
            kind = (nsat < 0) ? 0 : (k < nsat) ? int'($urandom_range(1, 2)) : 3;
            in_a[k*W +: W] = lane_val(kind);
            in_b[k*W +: W] = lane_val(kind);
        end
        in_mode = mode;
    endtask

    task automatic tick();
        beat_t e;
        int    pop;
        #1;
        if (out_valid && in_ready) begin
            chk("sb_has_beat", BW'(exp_q.size() != 0), BW'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_sum", out_sum, e.sum);
                chk("sb_even", BW'(out_is_even), BW'(e.even));
                chk("sb_sat", BW'(out_sat_flags), BW'(e.sat));
                pop = $countones(e.sat);
                if (in_clr_count) cnt_m = pop;
                else cnt_m = (cnt_m + pop > CMAX) ? CMAX : cnt_m + pop;
            end
        end else if (in_clr_count) begin
            cnt_m = 0;
        end
        if (in_valid && out_ready) exp_q.push_back(model(in_a, in_b, in_mode));
        @(posedge in_clk);
        #1;
        chk("count", BW'(out_sat_count), BW'(cnt_m));
    endtask

    task automatic send_drain(input int nsat, input logic mode);
        set_beat(nsat, mode);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BW-1:0] held;
        logic          acc;
        int            sent;
        int            n;

        // reset state
        repeat (2) @(posedge in_clk);
        #1;
        chk("rst_out_valid", BW'(out_valid), BW'(0));
        chk("rst_out_sum", out_sum, '0);
        chk("rst_count", BW'(out_sat_count), BW'(0));
        chk("rst_out_ready", BW'(out_ready), BW'(1));
        in_rst_n = 1'b1;

        // 1: 30+40 in saturate mode, latency 2
        for (int k = 0; k < C; k++) begin
            in_a[k*W +: W] = 32'd30;
            in_b[k*W +: W] = 32'd40;
        end
        in_mode  = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1 chk("t1_lat1_valid", BW'(out_valid), BW'(0));
        tick();
        #1 chk("t1_lat2_valid", BW'(out_valid), BW'(1));
        chk("t1_sum", out_sum, {4{32'd70}});
        chk("t1_even", BW'(out_is_even), BW'(4'hF));
        chk("t1_sat", BW'(out_sat_flags), BW'(4'h0));
        tick();
        chk("t1_count", BW'(out_sat_count), BW'(0));

        // 2: mixed lanes, two clamp
        in_a = {32'd7, 32'd100, 32'hFFFF_FFB0, 32'd60};
        in_b = {32'd0, 32'd0,   32'hFFFF_FFBA, 32'd50};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #1 chk("t2_sum", out_sum, {32'd7, 32'd100, 32'hFFFF_FF9C, 32'd100});
        chk("t2_sat", BW'(out_sat_flags), BW'(4'b0011));
        chk("t2_even", BW'(out_is_even), BW'(4'b0111));
        tick();
        chk("t2_count", BW'(out_sat_count), BW'(2));

        // 3: max+1 wrap then saturate, back to back
        for (int k = 0; k < C; k++) begin
            in_a[k*W +: W] = 32'h7FFF_FFFF;
            in_b[k*W +: W] = 32'd1;
        end
        in_mode  = 1'b1;
        in_valid = 1'b1;
        tick();
        in_mode = 1'b0;
        tick();
        in_valid = 1'b0;
        #1 chk("t3_wrap_sum", out_sum, {4{32'h8000_0000}});
        chk("t3_wrap_even", BW'(out_is_even), BW'(4'hF));
        chk("t3_wrap_sat", BW'(out_sat_flags), BW'(4'h0));
        tick();
        #1 chk("t3_sat_sum", out_sum, {4{32'd100}});
        chk("t3_sat_flags", BW'(out_sat_flags), BW'(4'hF));
        tick();
        chk("t3_count", BW'(out_sat_count), BW'(6));

        // 4: five-beat stream with back-pressure
        sent = 0;
        held = '0;
        set_beat(-1, 1'($urandom_range(0, 1)));
        for (int c = 0; c < 12; c++) begin
            in_valid = (sent < 5);
            in_ready = !(c >= 3 && c <= 5);
            #1;
            if (c >= 3 && c <= 5) chk("t4_stall_ready", BW'(out_ready), BW'(0));
            if (c == 4 || c == 5) chk("t4_hold_sum", out_sum, held);
            if (c >= 6 && c <= 9) chk("t4_no_gap", BW'(out_valid), BW'(1));
            acc = in_valid && out_ready;
            tick();
            if (c == 2) held = out_sum;
            if (acc) begin
                sent++;
                set_beat(-1, 1'($urandom_range(0, 1)));
            end
        end
        in_valid = 1'b0;
        in_ready = 1'b1;
        chk("t4_all_out", BW'(exp_q.size()), BW'(0));

        // 5: counter clear, saturation at the top, clear with transfer
        in_clr_count = 1'b1;
        tick();
        in_clr_count = 1'b0;
        chk("t5_clr_alone", BW'(out_sat_count), BW'(0));
        in_valid = 1'b1;
        for (int i = 0; i < (CMAX - 3) / 4; i++) begin
            set_beat(4, 1'b0);
            tick();
        end
        set_beat(2, 1'b0);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("t5_near_max", BW'(out_sat_count), BW'(CMAX - 1));
        send_drain(4, 1'b0);
        chk("t5_at_max", BW'(out_sat_count), BW'(CMAX));
        send_drain(4, 1'b0);
        chk("t5_no_wrap", BW'(out_sat_count), BW'(CMAX));
        set_beat(1, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 8) begin
            tick();
            n++;
        end
        chk("t5_wait_beat", BW'(out_valid), BW'(1));
        in_clr_count = 1'b1;
        tick();
        in_clr_count = 1'b0;
        chk("t5_clr_xfer", BW'(out_sat_count), BW'(1));

        // 6: async reset with two beats in flight
        in_ready = 1'b0;
        set_beat(4, 1'b0);
        in_valid = 1'b1;
        tick();
        set_beat(-1, 1'b0);
        tick();
        in_valid = 1'b0;
        #2 in_rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", BW'(out_valid), BW'(0));
        chk("t6_rst_count", BW'(out_sat_count), BW'(0));
        chk("t6_rst_sum", out_sum, '0);
        exp_q.delete();
        cnt_m = 0;
        #1 in_rst_n = 1'b1;
        in_ready = 1'b1;
        set_beat(3, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1 chk("t6_lat1_valid", BW'(out_valid), BW'(0));
        tick();
        #1 chk("t6_lat2_valid", BW'(out_valid), BW'(1));
        tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            in_ready     = ($urandom_range(0, 3) != 0);
            in_clr_count = ($urandom_range(0, 15) == 0);
            set_beat(int'($urandom_range(0, 5)) - 1, 1'($urandom_range(0, 1)));
            tick();
        end
        in_valid     = 1'b0;
        in_ready     = 1'b1;
        in_clr_count = 1'b0;
        repeat (4) tick();
        chk("rand_drained", BW'(exp_q.size()), BW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
